// File: rtl/cla_rr_seq_adder_if.sv
// Request/response bundle for cla_rr_seq_adder.
// Requester i occupies bits [i*WIDTH +: WIDTH] of req_a/req_b.
// rsp_ovf exists only when SIGNED_OVF_EN is defined.
interface cla_rr_seq_adder_if #(
  parameter int WIDTH = 12,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;
`ifdef SIGNED_OVF_EN
  logic                  rsp_ovf;
`endif

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef SIGNED_OVF_EN
    , input rsp_ovf
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef SIGNED_OVF_EN
    , output rsp_ovf
`endif
  );
endinterface

// File: rtl/cla_rr_seq_adder.sv
// Shared 4-bit carry-lookahead slice serving NREQ requesters.
// A round-robin arbiter grants one request at a time; the WIDTH-bit add is
// done one nibble per clock, LSB first, carry held in carry_q between nibbles.
// Optional macro SIGNED_OVF_EN adds rsp_ovf (two's-complement overflow).
module cla_rr_seq_adder #(
  parameter int WIDTH = 12,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
) (
  input logic               clk,
  input logic               rst_n,
  cla_rr_seq_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("WIDTH must be a positive multiple of 4");
  end
  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 1..8");
  end
  if ((1 << IDW) < NREQ) begin : g_bad_idw
    $error("IDW too narrow for NREQ");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // 4-bit carry-lookahead slice: returns {carry out, carry into bit 3, sum}.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q;
  logic [NW-1:0]     nib_idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [IDW-1:0]    id_q;
  logic              cout_q;
  logic              rsp_valid_q;
`ifdef SIGNED_OVF_EN
  logic              ovf_q;
`endif

  logic              found_s;
  logic [PW-1:0]     grant_idx_s;
  logic [PW-1:0]     nxt_ptr_s;
  logic [NREQ-1:0]   grant_s;
  logic [WIDTH-1:0]  sel_a_s, sel_b_s;
  logic              sel_cin_s;
  logic [3:0]        a_nib_s, b_nib_s;
  logic [5:0]        slice_s;
  logic              last_nib_s;

  // Round-robin search starting at rr_ptr_q for the first valid requester.
  always_comb begin
    int idx;
    idx         = 0;
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found_s && bus.req_valid[idx]) begin
        found_s     = 1'b1;
        grant_idx_s = PW'(idx);
      end else begin
        found_s     = found_s;
      end
    end
    grant_s   = found_s ? (NREQ'(1) << grant_idx_s) : '0;
    nxt_ptr_s = (int'(grant_idx_s) == NREQ - 1) ? '0 : grant_idx_s + PW'(1);
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_cin_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == PW'(i)) begin
        sel_a_s   = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_s   = bus.req_b[i*WIDTH +: WIDTH];
        sel_cin_s = bus.req_cin[i];
      end else begin
        sel_cin_s = sel_cin_s;
      end
    end
  end

  // Nibble mux feeding the shared slice from the latched operands.
  always_comb begin
    a_nib_s = 4'h0;
    b_nib_s = 4'h0;
    for (int j = 0; j < N; j++) begin
      if (nib_idx_q == NW'(j)) begin
        a_nib_s = a_q[j*4 +: 4];
        b_nib_s = b_q[j*4 +: 4];
      end else begin
        a_nib_s = a_nib_s;
      end
    end
    slice_s    = cla4(a_nib_s, b_nib_s, carry_q);
    last_nib_s = (nib_idx_q == NW'(N - 1));
  end

  // Grants are only visible while idle and out of reset.
  assign bus.req_ready = (state_q == IDLE && rst_n) ? grant_s : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
`ifdef SIGNED_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`endif

  // Next-state logic for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = found_s ? RUN : IDLE;
      RUN:     state_d = last_nib_s ? DONE : RUN;
      DONE:    state_d = bus.rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch the granted request, accumulate nibbles, present result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      nib_idx_q   <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      id_q        <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (found_s) begin
            a_q       <= sel_a_s;
            b_q       <= sel_b_s;
            carry_q   <= sel_cin_s;
            id_q      <= IDW'(grant_idx_s);
            nib_idx_q <= '0;
            rr_ptr_q  <= nxt_ptr_s;
            sum_q     <= '0;
            cout_q    <= 1'b0;
          end
        end
        RUN: begin
          for (int j = 0; j < N; j++) begin
            if (nib_idx_q == NW'(j)) sum_q[j*4 +: 4] <= slice_s[3:0];
          end
          carry_q <= slice_s[5];
          if (last_nib_s) begin
            nib_idx_q   <= '0;
            cout_q      <= slice_s[5];
            rsp_valid_q <= 1'b1;
`ifdef SIGNED_OVF_EN
            ovf_q       <= slice_s[5] ^ slice_s[4];
`endif
          end else begin
            nib_idx_q <= nib_idx_q + NW'(1);
          end
        end
        DONE: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_rr_seq_adder.sv
// Directed self-checking bench for cla_rr_seq_adder (WIDTH=12, NREQ=2).
module tb_cla_rr_seq_adder;
  localparam int WIDTH = 12;
  localparam int NREQ  = 2;
  localparam int IDW   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  cla_rr_seq_adder_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  cla_rr_seq_adder #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int id, input logic [11:0] a, input logic [11:0] b,
                         input logic cin);
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
    bus.req_cin[id]              = cin;
    bus.req_valid[id]            = 1'b1;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int t = 0; t < 20; t++) begin
      if (bus.req_ready !== '0) begin
        g  = bus.req_ready;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) begin
        lat = t;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  // Issue one request on requester id and wait for its response (not consumed).
  task automatic run_op(input int id, input logic [11:0] a, input logic [11:0] b,
                        input logic cin, output logic [11:0] sum, output logic cout,
                        output logic [IDW-1:0] rid, output logic ovf,
                        output logic [NREQ-1:0] g, output int lat, output bit ok);
    bit okg, okr;
    @(negedge clk);
    set_req(id, a, b, cin);
    #1;
    wait_grant(g, okg);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
    wait_rsp(lat, okr);
    sum  = bus.rsp_sum;
    cout = bus.rsp_cout;
    rid  = bus.rsp_id;
    ovf  = 1'b0;
`ifdef SIGNED_OVF_EN
    ovf  = bus.rsp_ovf;
`endif
    ok = okg && okr;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #11;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b expected 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", bus.rsp_valid); end
    checks++; if ({bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got sum=%h cout=%b id=%0d expected all 0", bus.rsp_sum, bus.rsp_cout, bus.rsp_id); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL idle_no_req_ready got %b expected 00", bus.req_ready); end
  endtask

  task automatic test_single();
    logic [11:0] s; logic c, o; logic [IDW-1:0] id; logic [NREQ-1:0] g; int lat; bit ok;
    run_op(0, 12'h019, 12'hCE9, 1'b1, s, c, id, o, g, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_handshake got timeout expected grant and response"); end
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_grant got %b expected 01", g); end
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency got %0d expected 3", lat); end
    checks++; if (s !== 12'hD03 || c !== 1'b0 || id !== 3'd0) begin errors++; $display("FAIL single_result got sum=%h cout=%b id=%0d expected D03 0 0", s, c, id); end
    consume();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_carry_chain();
    logic [11:0] va [2] = '{12'hFFF, 12'hF40};
    logic [11:0] vb [2] = '{12'hFFF, 12'hEC7};
    logic [11:0] vs [2] = '{12'hFFE, 12'hE07};
    logic [11:0] s; logic c, o; logic [IDW-1:0] id; logic [NREQ-1:0] g; int lat; bit ok;
    for (int n = 0; n < 2; n++) begin
      run_op(n, va[n], vb[n], 1'b0, s, c, id, o, g, lat, ok);
      checks++; if (!ok || lat != 3) begin errors++; $display("FAIL carry_latency[%0d] got ok=%0d lat=%0d expected 1 3", n, ok, lat); end
      checks++; if (s !== vs[n] || c !== 1'b1 || id !== IDW'(n)) begin errors++; $display("FAIL carry_result[%0d] got sum=%h cout=%b id=%0d expected %h 1 %0d", n, s, c, id, vs[n], n); end
      consume();
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g; logic [NREQ-1:0] eg; logic [11:0] es; logic [11:0] held;
    int lat; bit okg, okr;
    @(negedge clk);
    set_req(0, 12'h123, 12'h456, 1'b0);
    set_req(1, 12'hABC, 12'h544, 1'b1);
    #1;
    for (int n = 0; n < 4; n++) begin
      eg = (n % 2 == 0) ? 2'b01 : 2'b10;
      es = (n % 2 == 0) ? 12'h579 : 12'h001;
      wait_grant(g, okg);
      checks++; if (!okg || g !== eg) begin errors++; $display("FAIL rr_grant[%0d] got %b expected %b", n, g, eg); end
      @(posedge clk);
      #1;
      wait_rsp(lat, okr);
      checks++; if (!okr || lat != 3) begin errors++; $display("FAIL rr_latency[%0d] got ok=%0d lat=%0d expected 1 3", n, okr, lat); end
      checks++; if (bus.rsp_sum !== es || bus.rsp_cout !== (n % 2 == 1) || bus.rsp_id !== IDW'(n % 2)) begin errors++; $display("FAIL rr_result[%0d] got sum=%h cout=%b id=%0d expected %h %0d %0d", n, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, es, n % 2, n % 2); end
      if (n == 0) begin
        held = bus.rsp_sum;
        for (int h = 0; h < 5; h++) begin
          @(posedge clk);
          #1;
          checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== held || bus.rsp_id !== 3'd0 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL rr_hold[%0d] got valid=%b sum=%h id=%0d ready=%b expected 1 %h 0 00", h, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready, held); end
        end
      end
      consume();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_drop[%0d] got %b expected 0", n, bus.rsp_valid); end
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    logic [NREQ-1:0] g; int lat; bit okg, okr;
    @(negedge clk);
    set_req(0, 12'h0F3, 12'h012, 1'b0);
    #1;
    wait_grant(g, okg);
    checks++; if (!okg || g !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b expected 01", g); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    #2;
    set_req(1, 12'h111, 12'h222, 1'b0);
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got ready=%b valid=%b expected 00 0", bus.req_ready, bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 12'h000 || bus.rsp_cout !== 1'b0 || bus.rsp_id !== 3'd0) begin errors++; $display("FAIL midrst_data got sum=%h cout=%b id=%0d expected 000 0 0", bus.rsp_sum, bus.rsp_cout, bus.rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midrst_regrant got %b expected 01", bus.req_ready); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_rsp(lat, okr);
    checks++; if (!okr || lat != 3) begin errors++; $display("FAIL midrst_latency got ok=%0d lat=%0d expected 1 3", okr, lat); end
    checks++; if (bus.rsp_sum !== 12'h105 || bus.rsp_id !== 3'd0) begin errors++; $display("FAIL midrst_result got sum=%h id=%0d expected 105 0", bus.rsp_sum, bus.rsp_id); end
    consume();
  endtask

`ifdef SIGNED_OVF_EN
  task automatic test_ovf();
    logic [11:0] s; logic c, o; logic [IDW-1:0] id; logic [NREQ-1:0] g; int lat; bit ok;
    run_op(0, 12'h7FF, 12'h001, 1'b0, s, c, id, o, g, lat, ok);
    checks++; if (!ok || s !== 12'h800 || c !== 1'b0 || o !== 1'b1) begin errors++; $display("FAIL ovf_pos got sum=%h cout=%b ovf=%b expected 800 0 1", s, c, o); end
    consume();
    run_op(1, 12'h800, 12'hFFF, 1'b0, s, c, id, o, g, lat, ok);
    checks++; if (!ok || s !== 12'h7FF || c !== 1'b1 || o !== 1'b1) begin errors++; $display("FAIL ovf_neg got sum=%h cout=%b ovf=%b expected 7FF 1 1", s, c, o); end
    consume();
    run_op(0, 12'h123, 12'h456, 1'b0, s, c, id, o, g, lat, ok);
    checks++; if (!ok || s !== 12'h579 || o !== 1'b0) begin errors++; $display("FAIL ovf_none got sum=%h ovf=%b expected 579 0", s, o); end
    consume();
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_carry_chain();
    test_round_robin();
    test_reset_mid_op();
`ifdef SIGNED_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_rr_seq_adder.md
Name: cla_rr_seq_adder

Overview:
- Shares a single `fourbit_CLA` slice among NREQ requesters.
- Performs WIDTH-bit additions serially, one nibble per clock, LSB nibble first, with the carry held in a register between nibbles.
- Round-robin arbiter picks the requester; result is returned on a valid/ready response channel tagged with the requester ID.
- Area-saving alternative to `twelvebit_CLA` where multiple clients need infrequent wide adds.

Parameters:
- WIDTH, 12, operand/sum width; must be a multiple of 4 (elaboration error otherwise).
- NREQ, 2, number of requesters (1..8).
- IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry out of MSB.
- rsp_id  out  IDW  index of the requester that owns the result.

Behaviour:
- Interface: one clock domain `clk`; reset `rst_n` is asynchronous, active-low. Assertion immediately forces IDLE and clears all outputs/registers.
- Reset values: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rr_ptr=0, nib_idx=0, carry=0.
- FSM states: IDLE, RUN, DONE. N = WIDTH/4.
- IDLE:
  - req_ready is combinational: one-hot grant to the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - On a handshake edge: latch a, b, cin, id; set carry=cin, nib_idx=0, rr_ptr=(granted+1) mod NREQ; go to RUN.
  - No valid requests: stay in IDLE, pointer unchanged.
- RUN:
  - req_ready=0.
  - Each cycle the CLA slice gets a[nib_idx*4+:4], b[nib_idx*4+:4] and the carry register.
  - On the edge: sum nibble stored at the same position; carry <= slice co; nib_idx increments.
  - After nibble N-1 is committed: go to DONE; rsp_cout = final carry.
- DONE:
  - rsp_valid=1; rsp_sum/rsp_cout/rsp_id held stable until rsp_ready=1 on an edge, then go to IDLE, rsp_valid=0.
  - req_ready=0 throughout DONE; no request is accepted in the same cycle as the response handshake.
- Latency: rsp_valid rises exactly N cycles after the accept edge. Minimum issue interval is N+2 cycles.
- Requesters must hold req_valid and operands until req_ready. Deasserting req_valid before grant is permitted; nothing is recorded.
- Wrap: sum is modulo 2**WIDTH; overflow is reported only via rsp_cout.
- rst_n asserted mid-RUN or mid-DONE: operation is discarded and no response is issued. After release, arbitration restarts from requester 0.

Optional Feature:
- Macro SIGNED_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit, reset 0), valid with rsp_valid. Equals carry into the MSB XOR carry out of the MSB (two's-complement overflow), computed from the last nibble's internal carries.
- Undefined: port absent; no extra logic.

Test Plan:
- Single request, WIDTH=12: req0 a=0x019, b=0xCE9, cin=1 -> after 3 cycles rsp_sum=0xD03, rsp_cout=0, rsp_id=0.
- Carry chain across all nibbles: a=0xFFF, b=0xFFF, cin=0 -> rsp_sum=0xFFE, rsp_cout=1. Also a=0xF40, b=0xEC7, cin=0 -> rsp_sum=0xE07, rsp_cout=1.
- Round-robin: req0 and req1 held valid continuously -> grants alternate 0,1,0,1. Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid stays high and outputs stable, req_ready stays 0.
- Reset mid-op: assert rst_n=0 during RUN nibble 1 -> all outputs 0 immediately. After release, first grant goes to req0 even if req1 is also valid; no stale response appears.
- SIGNED_OVF_EN: a=0x7FF, b=0x001, cin=0 -> rsp_sum=0x800, rsp_ovf=1, rsp_cout=0. a=0x800, b=0xFFF -> rsp_sum=0x7FF, rsp_ovf=1, rsp_cout=1.
